mem_access_stage: RTL and testbench

Pipeline MEM stage of the RISC-V core: consumes the EX/MEM register outputs of the execute stage, performs word loads/stores over a req/ack data-memory port, resolves branch/jump/return redirects, and drives the MEM/WB pipeline register. It stalls upstream while a memory access is outstanding. A watchdog aborts accesses that are never acknowledged.

---
 rtl/mem_access_stage.sv | 155 +++++++++++++++
 tb/tb_mem_access_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM stage: word load/store over a req/ack port, branch/jump/return redirect,
// and the MEM/WB register. Stalls upstream while an access is outstanding.
module mem_access_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic        RegWrite_i,
    input  logic        Branch_i,
    input  logic        Jump_i,
    input  logic        Ret_i,
    input  logic        MemWrite_i,
    input  logic        EQ_i,
    input  logic [1:0]  WriteSrc_i,
    input  logic [31:0] ALUout_i,
    input  logic [31:0] pcPlus4_i,
    input  logic [31:0] pcPlusImm_i,
    input  logic [31:0] ImmOp_i,
    input  logic [31:0] regOp2_i,
    input  logic [4:0]  rd_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_o,
    output logic        redirect_o,
    output logic [31:0] redirectPC_o,
    output logic        valid_o,
    output logic        RegWrite_o,
    output logic [31:0] WBdata_o,
    output logic [4:0]  rd_o,
    output logic        fault_o
);

    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    localparam logic [15:0] LP_TLAST = 16'(TIMEOUT - 1);

    state_t      r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic [31:0] r_addr, r_wdata;
    logic        r_we, r_rw, r_fault;
    logic [4:0]  r_rd;
    logic        r_valid, r_regwrite;
    logic [31:0] r_wbdata;
    logic [4:0]  r_rd_o;

    logic        w_memop, w_timeout, w_issue;
    logic        w_valid_nxt, w_rw_nxt;
    logic [31:0] w_wb_nxt, w_wb_mux;
    logic [4:0]  w_rd_nxt;

    assign w_memop   = valid_i & (MemWrite_i | (WriteSrc_i == 2'b01));
    assign w_issue   = (r_state == S_IDLE) & w_memop;
    assign w_timeout = (r_state == S_BUSY) & ~mem_ack_i & (r_cnt == LP_TLAST);

    always_comb begin
        w_wb_mux = 32'd0;
        case (WriteSrc_i)
            2'b00:   w_wb_mux = ALUout_i;
            2'b10:   w_wb_mux = pcPlus4_i;
            2'b11:   w_wb_mux = ImmOp_i;
            default: w_wb_mux = 32'd0;
        endcase
    end

    // Next-state and MEM/WB load values; default is a bubble.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_valid_nxt = 1'b0;
        w_rw_nxt    = 1'b0;
        w_wb_nxt    = 32'd0;
        w_rd_nxt    = r_rd_o;
        case (r_state)
            S_IDLE: begin
                if (w_memop) begin
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = 16'd0;
                end else begin
                    w_valid_nxt = valid_i;
                    w_rw_nxt    = valid_i & RegWrite_i;
                    w_rd_nxt    = rd_i;
                    w_wb_nxt    = w_wb_mux;
                end
            end
            S_BUSY: begin
                if (mem_ack_i) begin
                    w_state_nxt = S_IDLE;
                    w_valid_nxt = 1'b1;
                    w_rw_nxt    = r_rw & ~r_we;
                    w_rd_nxt    = r_rd;
                    w_wb_nxt    = r_we ? 32'd0 : mem_rdata_i;
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                    w_valid_nxt = 1'b1;
                    w_rd_nxt    = r_rd;
                end else begin
                    w_cnt_nxt   = r_cnt + 16'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_cnt      <= 16'd0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_we       <= 1'b0;
            r_rw       <= 1'b0;
            r_rd       <= 5'd0;
            r_fault    <= 1'b0;
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_wbdata   <= 32'd0;
            r_rd_o     <= 5'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_valid    <= w_valid_nxt;
            r_regwrite <= w_rw_nxt;
            r_wbdata   <= w_wb_nxt;
            r_rd_o     <= w_rd_nxt;
            if (w_timeout) r_fault <= 1'b1;
            // Access operands are captured once so they stay stable for the whole request.
            if (w_issue) begin
                r_addr  <= {ALUout_i[31:2], 2'b00};
                r_wdata <= regOp2_i;
                r_we    <= MemWrite_i;
                r_rw    <= RegWrite_i;
                r_rd    <= rd_i;
            end
        end
    end

    assign mem_req_o    = (r_state == S_BUSY);
    assign mem_we_o     = r_we;
    assign mem_addr_o   = r_addr;
    assign mem_wdata_o  = r_wdata;
    assign stall_o      = w_issue | ((r_state == S_BUSY) & ~mem_ack_i & ~w_timeout);
    assign redirect_o   = valid_i & (r_state == S_IDLE) & ((Branch_i & EQ_i) | Jump_i | Ret_i);
    assign redirectPC_o = Ret_i ? {ALUout_i[31:1], 1'b0} : pcPlusImm_i;
    assign valid_o      = r_valid;
    assign RegWrite_o   = r_regwrite;
    assign WBdata_o     = r_wbdata;
    assign rd_o         = r_rd_o;
    assign fault_o      = r_fault;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage; retired MEM/WB results are checked
// against a queue of expected values pushed when each instruction is driven.
module tb_mem_access_stage;

    logic        clk_i = 1'b0, rst_i = 1'b1;
    logic        valid_i, RegWrite_i, Branch_i, Jump_i, Ret_i, MemWrite_i, EQ_i;
    logic [1:0]  WriteSrc_i;
    logic [31:0] ALUout_i, pcPlus4_i, pcPlusImm_i, ImmOp_i, regOp2_i;
    logic [4:0]  rd_i;
    logic        mem_req_o, mem_we_o, mem_ack_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic        stall_o, redirect_o, valid_o, RegWrite_o, fault_o;
    logic [31:0] redirectPC_o, WBdata_o;
    logic [4:0]  rd_o;

    typedef struct packed {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] wb;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    mem_access_stage #(.TIMEOUT(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .RegWrite_i(RegWrite_i),
        .Branch_i(Branch_i), .Jump_i(Jump_i), .Ret_i(Ret_i), .MemWrite_i(MemWrite_i),
        .EQ_i(EQ_i), .WriteSrc_i(WriteSrc_i), .ALUout_i(ALUout_i), .pcPlus4_i(pcPlus4_i),
        .pcPlusImm_i(pcPlusImm_i), .ImmOp_i(ImmOp_i), .regOp2_i(regOp2_i), .rd_i(rd_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .stall_o(stall_o), .redirect_o(redirect_o), .redirectPC_o(redirectPC_o),
        .valid_o(valid_o), .RegWrite_o(RegWrite_o), .WBdata_o(WBdata_o), .rd_o(rd_o),
        .fault_o(fault_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clr();
        {valid_i, RegWrite_i, Branch_i, Jump_i, Ret_i, MemWrite_i, EQ_i} = '0;
        WriteSrc_i = 2'b00;
        ALUout_i = 32'h0; pcPlus4_i = 32'h0; pcPlusImm_i = 32'h0;
        ImmOp_i = 32'h0; regOp2_i = 32'h0; rd_i = 5'd0;
        mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    endtask

    task automatic op(input logic rw, input logic [1:0] ws, input logic [31:0] alu,
                      input logic [4:0] rd);
        valid_i = 1'b1; RegWrite_i = rw; WriteSrc_i = ws; ALUout_i = alu; rd_i = rd;
    endtask

    // Scoreboard: every retired MEM/WB entry must match the oldest expectation.
    always @(negedge clk_i) begin
        if (!rst_i && valid_o) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid_o", {27'd0, rd_o, WBdata_o}, 64'd0);
                chk("unexpected_valid_o_flag", 64'(valid_o), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wb_RegWrite", 64'(RegWrite_o), 64'(e.rw));
                chk("wb_rd", 64'(rd_o), 64'(e.rd));
                chk("wb_data", 64'(WBdata_o), 64'(e.wb));
            end
        end
    end

    initial begin
        int n;
        clr();
        #2;
        chk("rst_req", 64'(mem_req_o), 64'd0);
        chk("rst_mem_regs", {mem_we_o, mem_addr_o}, 64'd0);
        chk("rst_wdata", 64'(mem_wdata_o), 64'd0);
        chk("rst_wb", {valid_o, RegWrite_o, rd_o, WBdata_o}, 64'd0);
        chk("rst_fault", 64'(fault_o), 64'd0);
        tick(); tick();
        rst_i = 1'b0;

        // ALU, pcPlus4 and ImmOp writeback selections
        op(1'b1, 2'b00, 32'h1234, 5'd5);
        #1 chk("alu_stall", 64'(stall_o), 64'd0);
        sb.push_back('{1'b1, 5'd5, 32'h1234});
        tick();
        op(1'b1, 2'b10, 32'h0, 5'd6); pcPlus4_i = 32'h44;
        sb.push_back('{1'b1, 5'd6, 32'h44});
        tick();
        op(1'b1, 2'b11, 32'h0, 5'd7); ImmOp_i = 32'hFFFF_F000;
        sb.push_back('{1'b1, 5'd7, 32'hFFFF_F000});
        tick();
        clr();
        mem_ack_i = 1'b1; mem_rdata_i = 32'h5555;   // ack while idle must be ignored
        tick();
        clr();
        tick();

        // Load acked in the 4th BUSY cycle (also the timeout boundary count)
        op(1'b1, 2'b01, 32'h1003, 5'd9);
        sb.push_back('{1'b1, 5'd9, 32'hDEAD_BEEF});
        n = 0;
        #1 chk("ld_issue_req", 64'(mem_req_o), 64'd0);
        for (int c = 0; c < 5; c++) begin
            if (c == 4) begin mem_ack_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF; end
            #1;
            if (stall_o) n++;
            if (c == 2) begin
                chk("ld_addr", 64'(mem_addr_o), 64'h1000);
                chk("ld_we", {mem_req_o, mem_we_o}, 64'b10);
            end
            tick();
        end
        clr();
        chk("ld_stall_cycles", 64'(n), 64'd4);
        chk("ld_req_drop", 64'(mem_req_o), 64'd0);

        // Store with immediate ack
        op(1'b1, 2'b00, 32'h2000, 5'd3); MemWrite_i = 1'b1; regOp2_i = 32'hCAFE_0000;
        sb.push_back('{1'b0, 5'd3, 32'h0});
        tick();
        chk("st_req", {mem_req_o, mem_we_o}, 64'b11);
        chk("st_wdata", 64'(mem_wdata_o), 64'hCAFE_0000);
        chk("st_addr", 64'(mem_addr_o), 64'h2000);
        mem_ack_i = 1'b1;
        #1 chk("st_stall_ack", 64'(stall_o), 64'd0);
        tick();
        clr();
        chk("st_req_one_cycle", 64'(mem_req_o), 64'd0);

        // Redirects
        op(1'b0, 2'b00, 32'h0, 5'd0); Branch_i = 1'b1; EQ_i = 1'b1; pcPlusImm_i = 32'h80;
        #1 chk("br_taken", {redirect_o, redirectPC_o}, {31'd0, 1'b1, 32'h80});
        EQ_i = 1'b0;
        #1 chk("br_not_taken", 64'(redirect_o), 64'd0);
        sb.push_back('{1'b0, 5'd0, 32'h0});
        tick();
        op(1'b1, 2'b10, 32'h205, 5'd1); Ret_i = 1'b1; Jump_i = 1'b1; pcPlus4_i = 32'h30;
        #1 chk("ret", {redirect_o, redirectPC_o}, {31'd0, 1'b1, 32'h204});
        Ret_i = 1'b0;
        #1 chk("jump", {redirect_o, redirectPC_o}, {31'd0, 1'b1, 32'h80});
        sb.push_back('{1'b1, 5'd1, 32'h30});
        tick();
        clr();

        // Load never acked: watchdog aborts after TIMEOUT request cycles
        op(1'b1, 2'b01, 32'h3000, 5'd10);
        sb.push_back('{1'b0, 5'd10, 32'h0});
        n = 0;
        tick();
        for (int c = 0; c < 6; c++) begin
            if (mem_req_o) n++;
            if (c == 3) chk("to_stall_drop", 64'(stall_o), 64'd0);
            if (c == 2) chk("to_stall_wait", 64'(stall_o), 64'd1);
            tick();
            if (c == 3) clr();
        end
        chk("to_req_cycles", 64'(n), 64'd4);
        chk("to_fault", 64'(fault_o), 64'd1);

        // Reset in the middle of an access
        op(1'b1, 2'b01, 32'h4000, 5'd11);
        tick();
        clr();
        valid_i = 1'b1; WriteSrc_i = 2'b01;   // EX/MEM held during stall
        chk("rst_busy_req", 64'(mem_req_o), 64'd1);
        rst_i = 1'b1;
        #1 chk("rst_mid_req", 64'(mem_req_o), 64'd0);
        chk("rst_mid_fault", 64'(fault_o), 64'd0);
        chk("rst_mid_wb", {valid_o, RegWrite_o, rd_o, WBdata_o}, 64'd0);
        clr();
        tick();
        rst_i = 1'b0;
        op(1'b1, 2'b00, 32'hABCD, 5'd12);
        #1 chk("post_rst_stall", 64'(stall_o), 64'd0);
        sb.push_back('{1'b1, 5'd12, 32'hABCD});
        tick();
        clr();
        tick(); tick();

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
